// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-master arbiter in front of the single-port 2048x32 data memory.
//   Master 0 (CPU LSU) has fixed priority. Master 1 (DMA/peripheral bridge) is
//   force-granted after MAX_WAIT consecutive denied cycles. At most one access
//   is issued per cycle. Read data returns one cycle after the grant, matching
//   the memory's registered read port.
// Ports
//   clk, rst                   clock; synchronous active-high reset
//   mX_req/addr/we/wdata       master X request and payload, held until mX_gnt
//   mX_gnt                     master X accepted this cycle (combinational)
//   mX_rvalid/rdata            master X response, one cycle after accept
//   mem_en/we/addr/wdata       memory request side
//   mem_rdata                  memory read data, valid the cycle after mem_en
module dmem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_owner_q, resp_owner_d;
  logic       force_m1;

  // Grants are blocked outright during reset so nothing reaches the memory.
  always_comb begin
    force_m1 = m1_req && (wait_cnt_q == WAIT_MAX);
    m1_gnt   = !rst && m1_req && (!m0_req || force_m1);
    m0_gnt   = !rst && m0_req && !m1_gnt;
    mem_en   = m0_gnt | m1_gnt;
  end

  always_comb begin
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else if (m0_gnt) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!m1_req || m1_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    resp_valid_d = mem_en;
    resp_owner_d = m1_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  // A response already in flight when rst rises is dropped in that same
  // cycle; the master re-issues the access after reset.
  assign m0_rvalid = !rst && resp_valid_q && !resp_owner_q;
  assign m1_rvalid = !rst && resp_valid_q &&  resp_owner_q;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [10:0] m0_addr, m1_addr;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(11), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: registered read, read-before-write, we[i] enables byte i
  // (bits 8i+7:8i).
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int max_wait;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[11'h7FF] = 32'h12345678;
    mem[11'h020] = 32'h11223344;
    mem[11'h021] = 32'h11223344;
    mem_rdata = 32'h0;

    // 1. Reset with both requests held
    rst = 1'b1;
    m0_req = 1'b1; m0_addr = 11'h001; m0_we = 4'h0; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_addr = 11'h002; m1_we = 4'h0; m1_wdata = 32'h0;
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
      chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      step();
    end
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    #1;
    chk("post_rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("post_rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("post_rst_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("idle_mem_addr", 32'(mem_addr), 32'd0);
    chk("idle_mem_we", 32'(mem_we), 32'd0);

    // 2. m0 write then read
    m0_req = 1'b1; m0_addr = 11'h010; m0_we = 4'hF; m0_wdata = 32'hDEADBEEF;
    #1;
    chk("m0_wr_gnt", 32'(m0_gnt), 32'd1);
    chk("m0_wr_mem_addr", 32'(mem_addr), 32'h010);
    chk("m0_wr_mem_we", 32'(mem_we), 32'hF);
    chk("m0_wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    m0_we = 4'h0; m0_wdata = 32'h0;
    #1;
    chk("m0_wr_rvalid", 32'(m0_rvalid), 32'd1);
    chk("m0_rd_gnt", 32'(m0_gnt), 32'd1);
    step();
    m0_req = 1'b0;
    #1;
    chk("m0_rd_rvalid", 32'(m0_rvalid), 32'd1);
    chk("m0_rd_rdata", m0_rdata, 32'hDEADBEEF);
    chk("m0_rd_m1_rvalid", 32'(m1_rvalid), 32'd0);
    step();

    // 3. Continuous contention: m0,m0,m0,m0,m1 repeating
    m0_req = 1'b1; m0_addr = 11'h100;
    m1_req = 1'b1; m1_addr = 11'h200;
    max_wait = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("cont_m1_gnt_%0d", i), 32'(m1_gnt), 32'((i % 5) == 4));
      chk($sformatf("cont_m0_gnt_%0d", i), 32'(m0_gnt), 32'((i % 5) != 4));
      chk($sformatf("cont_wait_%0d", i), 32'(dut.wait_cnt_q), 32'(i % 5));
      if (i > 0) chk($sformatf("cont_m1_rvalid_%0d", i), 32'(m1_rvalid), 32'(((i - 1) % 5) == 4));
      if (int'(dut.wait_cnt_q) > max_wait) max_wait = int'(dut.wait_cnt_q);
      step();
    end
    chk("cont_wait_peak", 32'(max_wait), 32'd4);
    m0_req = 1'b0; m1_req = 1'b0;
    step();

    // 4. m1 alone reads 0x7FF
    m1_req = 1'b1; m1_addr = 11'h7FF; m1_we = 4'h0;
    #1;
    chk("m1_rd_gnt", 32'(m1_gnt), 32'd1);
    chk("m1_rd_m0_gnt", 32'(m0_gnt), 32'd0);
    step();
    m1_req = 1'b0;
    #1;
    chk("m1_rd_rvalid", 32'(m1_rvalid), 32'd1);
    chk("m1_rd_rdata", m1_rdata, 32'h12345678);
    chk("m1_rd_m0_rvalid", 32'(m0_rvalid), 32'd0);

    // 5. Byte writes: response carries the pre-write word
    m1_req = 1'b1; m1_addr = 11'h020; m1_we = 4'b0001; m1_wdata = 32'h000000AA;
    #1;
    chk("bw_gnt", 32'(m1_gnt), 32'd1);
    step();
    m1_we = 4'h0; m1_wdata = 32'h0;
    #1;
    chk("bw_rvalid", 32'(m1_rvalid), 32'd1);
    chk("bw_old_data", m1_rdata, 32'h11223344);
    step();
    m1_addr = 11'h021; m1_we = 4'b1000; m1_wdata = 32'hAA000000;
    #1;
    chk("bw_rdback", m1_rdata, 32'h112233AA);
    chk("bw_hi_mem_we", 32'(mem_we), 32'b1000);
    step();
    m1_we = 4'h0; m1_wdata = 32'h0;
    step();
    m1_req = 1'b0;
    #1;
    chk("bw_hi_rdback", m1_rdata, 32'hAA223344);
    step();

    // 6. Reset arriving the cycle after an m0 grant
    m0_req = 1'b1; m0_addr = 11'h010; m0_we = 4'h0;
    #1;
    chk("rmid_gnt", 32'(m0_gnt), 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("rmid_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rmid_gnt_blocked", 32'(m0_gnt), 32'd0);
    chk("rmid_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
    step();
    rst = 1'b0; m0_req = 1'b0;
    #1;
    chk("rmid_after_rvalid", 32'(m0_rvalid), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
